// File: rtl/rd_stream_pkg.sv
// rd_stream_pkg: shared sizing helpers and index/count types for the read-side stream adapter.
package rd_stream_pkg;
  localparam int OBUF_DEPTH_DEF = 3;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef logic [clog2(OBUF_DEPTH_DEF)-1:0] obuf_idx_t;
  typedef logic [clog2(OBUF_DEPTH_DEF+1)-1:0] obuf_cnt_t;
endpackage

// File: rtl/rd_stream_obuf.sv
// rd_stream_obuf: small register FIFO; head/tail wrap at DEPTH so any depth >= 2 works.
module rd_stream_obuf
  import rd_stream_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 3,
  localparam int IW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] head, tail;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction
  always_ff @(posedge rclk)
    if (push) mem[tail] <= din;
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = mem[head];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter: async-FIFO read side to AXI-Stream master with credit-based prefetch.
// Define RD_STREAM_TLAST_EN to generate m_tlast every PKT_BEATS handshakes.
module rd_stream_adapter
  import rd_stream_pkg::*;
#(
  parameter int DATASIZE = 32,
  parameter int OBUF_DEPTH = 3,
  parameter int RD_LATENCY = 1,
  parameter int PKT_BEATS = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATASIZE-1:0] m_tdata,
  output logic                m_tlast
);
  localparam int CW = clog2(OBUF_DEPTH + 1);
  logic [CW-1:0] count;
  logic rd_pend, push, pop, full, empty;
  if (RD_LATENCY > 1 || OBUF_DEPTH < 2 || PKT_BEATS < 1) begin : g_bad_cfg
    $error("rd_stream_adapter: unsupported parameter combination");
  end
  // Reads in flight reserve a slot, so the buffer can never be pushed while full.
  assign rinc = rrst_n & ~rempty & ((CW+1)'(count) + (CW+1)'(rd_pend) < (CW+1)'(OBUF_DEPTH));
  if (RD_LATENCY == 0) begin : g_comb_rd
    assign rd_pend = 1'b0;
    assign push    = rinc;
  end else begin : g_reg_rd
    always_ff @(posedge rclk)
      if (!rrst_n) rd_pend <= 1'b0;
      else rd_pend <= rinc;
    assign push = rd_pend;
  end
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = ~empty;
  rd_stream_obuf #(.DW(DATASIZE), .DEPTH(OBUF_DEPTH)) u_obuf (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .push  (push),
    .din   (rdata),
    .pop   (pop),
    .dout  (m_tdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  a_no_push_full: assert property (@(posedge rclk) disable iff (!rrst_n) !(push && full));
`ifdef RD_STREAM_TLAST_EN
  localparam int BW = clog2(PKT_BEATS);
  logic [BW-1:0] beat_cnt;
  always_ff @(posedge rclk)
    if (!rrst_n) beat_cnt <= '0;
    else if (pop) beat_cnt <= (beat_cnt == BW'(PKT_BEATS - 1)) ? '0 : beat_cnt + 1'b1;
  assign m_tlast = m_tvalid & (beat_cnt == BW'(PKT_BEATS - 1));
`else
  assign m_tlast = 1'b0;
`endif
endmodule

// File: tb/tb_rd_stream_adapter.sv
// tb_rd_stream_adapter: scoreboard bench with a registered-read FIFO source model.
module tb_rd_stream_adapter;
  localparam int PKT = 4;
  logic rclk, rrst_n, rempty, rinc, m_tvalid, m_tready, m_tlast;
  logic [31:0] rdata, m_tdata, prev_d;
  logic [31:0] src_q[$], exp_q[$];
  int n_cmp = 0, n_err = 0, beats = 0, rinc_cnt = 0, pkt_idx = 0, gap_from = 0;
  bit src_hold = 1, rdy_mode = 0, rdy_val = 0, gap_mode = 0, prev_vnr = 0;

  rd_stream_adapter #(.DATASIZE(32), .OBUF_DEPTH(3), .RD_LATENCY(1), .PKT_BEATS(PKT)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rinc(rinc), .rdata(rdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
  );

  initial rclk = 0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(posedge rclk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic load(input logic [31:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO source: rinc sampled mid-cycle, registered read data and empty flag after the edge.
  initial begin
    bit r;
    forever begin
      @(negedge rclk);
      r = rinc;
      @(posedge rclk);
      #1;
      if (!src_hold) begin
        if (r && src_q.size() != 0) rdata = src_q.pop_front();
        rempty = src_q.size() == 0;
      end
    end
  end

  initial begin
    m_tready = 0;
    forever begin
      @(posedge rclk);
      #1;
      m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_vnr = 0;
      pkt_idx = 0;
    end else begin
      if (prev_vnr) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_d);
      end
      check("count_max", dut.u_obuf.count > 3, 0);
      if (gap_mode && beats > gap_from && exp_q.size() != 0) check("no_gap", m_tvalid, 1);
      if (m_tvalid) begin
`ifdef RD_STREAM_TLAST_EN
        check("tlast", m_tlast, pkt_idx == PKT - 1);
`else
        check("tlast", m_tlast, 0);
`endif
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("extra_beat", m_tdata, 32'hdead_beef);
        else check("data", m_tdata, exp_q.pop_front());
        beats++;
        pkt_idx = (pkt_idx + 1) % PKT;
      end
      prev_vnr = m_tvalid & ~m_tready;
      prev_d = m_tdata;
      if (rinc) rinc_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, rc0;
    rrst_n = 0;
    rempty = 0;
    rdata = 'x;
    for (int i = 0; i < 3; i++) begin
      @(posedge rclk);
      #1;
      check("rst_rinc", rinc, 0);
      check("rst_valid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
    end
    check("rst_count", dut.u_obuf.count, 0);
    rempty = 1;
    src_hold = 0;
    rrst_n = 1;
    rdy_val = 1;
    repeat (5) @(posedge rclk);
    #2;
    rc0 = rinc_cnt;
    load(32'hA5A5_0001);
    @(posedge rclk); #3;
    check("t2_valid_n", m_tvalid, 0);
    @(posedge rclk); #3;
    check("t2_valid_n1", m_tvalid, 0);
    @(posedge rclk); #3;
    check("t2_valid_n2", m_tvalid, 1);
    check("t2_data", m_tdata, 32'hA5A5_0001);
    drain(20);
    repeat (3) @(posedge rclk);
    check("t2_rinc_once", rinc_cnt - rc0, 1);
    #2;
    b0 = beats;
    gap_from = beats;
    gap_mode = 1;
    for (int i = 0; i < 64; i++) load(i);
    drain(300);
    gap_mode = 0;
    check("t3_beats", beats - b0, 64);
    #2;
    b0 = beats;
    rdy_mode = 1;
    for (int i = 0; i < 64; i++) load(32'h100 + i);
    drain(1000);
    rdy_mode = 0;
    check("t4_beats", beats - b0, 64);
    #2;
    b0 = beats;
    for (int i = 0; i < 20; i++) load(32'h200 + i);
    for (int i = 0; i < 200 && beats < b0 + 6; i++) begin
      @(negedge rclk);
      #1;
    end
    check("t5_reach", beats >= b0 + 6, 1);
    @(posedge rclk); #1;
    rrst_n = 0;
    @(posedge rclk); #1;
    check("t5_valid", m_tvalid, 0);
    check("t5_rinc", rinc, 0);
    check("t5_count", dut.u_obuf.count, 0);
    #1;
    exp_q = src_q;
    rrst_n = 1;
    drain(200);
    check("t5_src_empty", src_q.size(), 0);
    @(posedge rclk); #1;
    rrst_n = 0;
    @(posedge rclk); #1;
    rrst_n = 1;
    #1;
    b0 = beats;
    for (int i = 0; i < 10; i++) load(32'h300 + i);
    drain(100);
    repeat (3) @(posedge rclk);
    check("t6_beats", beats - b0, 10);
`ifdef RD_STREAM_TLAST_EN
    check("t6_beat_cnt", dut.beat_cnt, 2);
`else
    check("t6_tlast_idle", m_tlast, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
